plic_claim_ctrl: RTL

Claim/complete sequencer for the PLIC arbitration datapath, serving one target (hart 0). It converts CPU claim-register reads and complete-register writes into the `claim_id`/`cmplt_id` controls consumed by the arbiter and gateways. It holds a nesting stack of in-service interrupt IDs so that only strictly higher-priority sources can preempt. It inserts settle cycles so that the arbiter pipeline and the pending registers reflect each claim or complete before the next request is accepted.

---
 rtl/plic_claim_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/plic_claim_ctrl.sv
// Claim/complete sequencer for one PLIC target: turns claim reads and complete
// writes into arbiter/gateway controls and keeps a nesting stack of in-service IDs.
module plic_claim_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ARB_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       claim_req,
  input  logic       cmplt_req,
  input  logic [7:0] cmplt_wdata,
  output logic       req_ready,
  output logic       claim_rvalid,
  output logic [7:0] claim_rdata,
  input  logic [7:0] final_id,
  input  logic       ext_irq,
  output logic [7:0] claim_id,
  output logic [7:0] cmplt_id,
  output logic       ip_clr,
  output logic [7:0] ip_clr_id,
  output logic [3:0] nest_depth,
  output logic       err_ovf,
  output logic       err_cmplt,
  input  logic       err_clr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    CLAIM  = 3'd2,
    CMPLT  = 3'd3,
    SETTLE = 3'd4
  } state_t;

  localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);
  localparam logic [2:0] LAT       = 3'(ARB_LAT);

  state_t     state_r, state_next_s;
  logic [2:0] cnt_r, cnt_next_s;
  logic [7:0] stack_r [DEPTH];
  logic [3:0] depth_r;

  logic       req_ready_r, claim_rvalid_r, ip_clr_r, err_ovf_r, err_cmplt_r;
  logic [7:0] claim_rdata_r, ip_clr_id_r, cmplt_id_r;

  logic full_s, claim_dec_s, grant_s, ovf_set_s;
  logic cmplt_acc_s, cmplt_ok_s, cmplt_bad_s, push_s, pop_s;

  // Outputs are registered one cycle ahead so they coincide with CLAIM/CMPLT.
  assign full_s      = (depth_r == DEPTH_MAX);
  assign claim_dec_s = (state_next_s == CLAIM);
  assign grant_s     = claim_dec_s && ext_irq && (final_id != 8'd0) && !full_s;
  assign ovf_set_s   = claim_dec_s && ext_irq && full_s;
  assign cmplt_acc_s = (state_r == IDLE) && cmplt_req;
  assign cmplt_ok_s  = cmplt_acc_s && (cmplt_wdata != 8'd0) && (cmplt_wdata == stack_r[0]);
  assign cmplt_bad_s = cmplt_acc_s && (cmplt_wdata != 8'd0) && (cmplt_wdata != stack_r[0]);
  assign push_s      = (state_r == CLAIM) && ip_clr_r;
  assign pop_s       = (state_r == CMPLT) && (cmplt_id_r != 8'd0);

  // Next-state and wait/settle counter reload.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (cmplt_req) begin
          state_next_s = CMPLT;
        end else if (claim_req) begin
          if (ARB_LAT == 0) begin
            state_next_s = CLAIM;
          end else begin
            state_next_s = WAIT;
            cnt_next_s   = LAT - 3'd1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 3'd0) begin
          state_next_s = CLAIM;
        end else begin
          cnt_next_s = cnt_r - 3'd1;
        end
      end
      CLAIM, CMPLT: begin
        state_next_s = SETTLE;
        cnt_next_s   = LAT;
      end
      SETTLE: begin
        if (cnt_r == 3'd0) begin
          state_next_s = IDLE;
        end else begin
          cnt_next_s = cnt_r - 3'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 3'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r    <= 1'b1;
      claim_rvalid_r <= 1'b0;
      claim_rdata_r  <= 8'd0;
      ip_clr_r       <= 1'b0;
      ip_clr_id_r    <= 8'd0;
      cmplt_id_r     <= 8'd0;
    end else begin
      req_ready_r    <= (state_next_s == IDLE);
      claim_rvalid_r <= claim_dec_s;
      claim_rdata_r  <= grant_s ? final_id : 8'd0;
      ip_clr_r       <= grant_s;
      ip_clr_id_r    <= grant_s ? final_id : 8'd0;
      cmplt_id_r     <= cmplt_ok_s ? cmplt_wdata : 8'd0;
    end
  end

  // Shift-register nesting stack; entry 0 is the ID in service, vacated slots read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stack_r[i] <= 8'd0;
      depth_r <= 4'd0;
    end else if (push_s) begin
      stack_r[0] <= ip_clr_id_r;
      for (int i = 1; i < DEPTH; i++) stack_r[i] <= stack_r[i-1];
      depth_r <= depth_r + 4'd1;
    end else if (pop_s) begin
      for (int i = 0; i < DEPTH - 1; i++) stack_r[i] <= stack_r[i+1];
      stack_r[DEPTH-1] <= 8'd0;
      depth_r <= depth_r - 4'd1;
    end else begin
      depth_r <= depth_r;
    end
  end

  // Sticky error flags; a clear beats a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_r   <= 1'b0;
      err_cmplt_r <= 1'b0;
    end else if (err_clr) begin
      err_ovf_r   <= 1'b0;
      err_cmplt_r <= 1'b0;
    end else begin
      err_ovf_r   <= err_ovf_r | ovf_set_s;
      err_cmplt_r <= err_cmplt_r | cmplt_bad_s;
    end
  end

  assign req_ready    = req_ready_r;
  assign claim_rvalid = claim_rvalid_r;
  assign claim_rdata  = claim_rdata_r;
  assign ip_clr       = ip_clr_r;
  assign ip_clr_id    = ip_clr_id_r;
  assign cmplt_id     = cmplt_id_r;
  assign claim_id     = stack_r[0];
  assign nest_depth   = depth_r;
  assign err_ovf      = err_ovf_r;
  assign err_cmplt    = err_cmplt_r;

endmodule
